// File: rtl/spi_mem_host_pkg.sv
// Shared definitions for the SPI memory host and the SPI-slave-to-APB bridge.
// Contents:
//   state_e   - host controller FSM state encoding
//   DIR_WRITE - direction byte sent for a write transaction
//   DIR_READ  - direction byte sent for a read transaction
package spi_mem_host_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StDir,
        StData,
        StWaitRx,
        StStop
    } state_e;

    localparam logic [7:0] DIR_WRITE = 8'h01;
    localparam logic [7:0] DIR_READ  = 8'h00;

endpackage

// File: rtl/spi_mem_host.sv
// SPI memory host: turns a command (write/read, address, length) into a byte
// sequence for an SPI byte engine: start, address bytes (LSB first), direction
// byte, then data bytes, then stop. One engine byte is outstanding at a time.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   cmd_valid/ready, cmd_write,
//   cmd_addr, cmd_len                 - command handshake and fields
//   wdata_valid/ready, wdata          - write byte stream (into the host)
//   rdata_valid/ready, rdata          - read byte stream (out of the host)
//   eng_start, eng_stop               - chip-select assert / release pulses
//   eng_tx_valid/ready, eng_tx_byte   - byte to shift out
//   eng_rx_valid, eng_rx_byte         - byte shifted in, one per tx byte
//   busy, done                        - activity flag, end-of-transaction pulse
module spi_mem_host
    import spi_mem_host_pkg::*;
#(
    parameter int unsigned ADDR_BYTES = 1,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_BYTES*8-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [7:0]              wdata,
    output logic                    rdata_valid,
    input  logic                    rdata_ready,
    output logic [7:0]              rdata,
    output logic                    eng_start,
    output logic                    eng_stop,
    output logic                    eng_tx_valid,
    input  logic                    eng_tx_ready,
    output logic [7:0]              eng_tx_byte,
    input  logic                    eng_rx_valid,
    input  logic [7:0]              eng_rx_byte,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned ADDR_W = ADDR_BYTES * 8;
    // Wide enough for ADDR_BYTES + 1 + (2^LEN_WIDTH - 1) slots.
    localparam int unsigned SLOT_W = LEN_WIDTH + $clog2(ADDR_BYTES + 2);
    localparam int unsigned AIDX_W = $clog2(ADDR_BYTES + 1);
    localparam logic [AIDX_W-1:0] ADDR_LAST = AIDX_W'(ADDR_BYTES);

    state_e              state_q, state_d;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SLOT_W-1:0]   slots_left_q;
    logic [AIDX_W-1:0]   addr_idx_q;
    logic                dir_sent_q;
    logic                rx_keep_q;
    logic                len0_done_q;
    logic                rdata_valid_q;
    logic [7:0]          rdata_q;
    logic                stop_fire;
    logic                cmd_hs;
    logic                tx_hs;
    logic [SLOT_W-1:0]   slots_total;

    assign cmd_ready   = (state_q == StIdle) && !rst;
    assign cmd_hs      = cmd_valid && cmd_ready;
    assign tx_hs       = eng_tx_valid && eng_tx_ready;
    // Reads fold data byte 0 into the DIR slot, so they need one slot fewer.
    assign slots_total = SLOT_W'(ADDR_BYTES) + SLOT_W'(cmd_len) + SLOT_W'(cmd_write);

    assign busy        = (state_q != StIdle);
    assign done        = len0_done_q || stop_fire;
    assign eng_stop    = stop_fire;
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;

    always_comb begin
        state_d      = state_q;
        eng_start    = 1'b0;
        stop_fire    = 1'b0;
        eng_tx_valid = 1'b0;
        eng_tx_byte  = 8'h00;
        wdata_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_hs && (cmd_len != '0)) state_d = StStart;
            end
            StStart: begin
                eng_start = 1'b1;
                state_d   = StAddr;
            end
            StAddr: begin
                eng_tx_valid = 1'b1;
                eng_tx_byte  = addr_q[7:0];
                if (eng_tx_ready) state_d = StWaitRx;
            end
            StDir: begin
                eng_tx_valid = 1'b1;
                eng_tx_byte  = write_q ? DIR_WRITE : DIR_READ;
                if (eng_tx_ready) state_d = StWaitRx;
            end
            StData: begin
                if (write_q) begin
                    eng_tx_valid = wdata_valid;
                    eng_tx_byte  = wdata;
                    wdata_ready  = eng_tx_ready;
                end else begin
                    // Hold off the next dummy byte until the previous read byte is taken.
                    eng_tx_valid = !rdata_valid_q;
                end
                if (tx_hs) state_d = StWaitRx;
            end
            StWaitRx: begin
                if (eng_rx_valid) begin
                    if (slots_left_q == SLOT_W'(1)) state_d = StStop;
                    else if (addr_idx_q != ADDR_LAST) state_d = StAddr;
                    else if (!dir_sent_q)             state_d = StDir;
                    else                              state_d = StData;
                end
            end
            StStop: begin
                // Wait for the final read byte to drain before releasing chip select.
                if (!rdata_valid_q) begin
                    stop_fire = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            write_q       <= 1'b0;
            addr_q        <= '0;
            slots_left_q  <= '0;
            addr_idx_q    <= '0;
            dir_sent_q    <= 1'b0;
            rx_keep_q     <= 1'b0;
            len0_done_q   <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            len0_done_q <= cmd_hs && (cmd_len == '0);
            if (cmd_hs) begin
                write_q      <= cmd_write;
                addr_q       <= cmd_addr;
                slots_left_q <= slots_total;
                addr_idx_q   <= '0;
                dir_sent_q   <= 1'b0;
            end
            if (tx_hs) begin
                rx_keep_q <= !write_q && (state_q != StAddr);
                if (state_q == StAddr) begin
                    addr_q     <= addr_q >> 8;
                    addr_idx_q <= addr_idx_q + AIDX_W'(1);
                end
                if (state_q == StDir) dir_sent_q <= 1'b1;
            end
            if (rdata_valid_q && rdata_ready) rdata_valid_q <= 1'b0;
            if ((state_q == StWaitRx) && eng_rx_valid) begin
                slots_left_q <= slots_left_q - SLOT_W'(1);
                if (rx_keep_q) begin
                    rdata_q       <= eng_rx_byte;
                    rdata_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_host.sv
// Bench for spi_mem_host (ADDR_BYTES=2). A behavioural SPI memory device answers
// the engine interface; a scoreboard holds the expected tx byte sequence, read
// data and end-of-transaction events computed from a reference memory array.
module tb_spi_mem_host;

    localparam int AB = 2;
    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [7:0]  wdata;
    logic        rdata_valid, rdata_ready;
    logic [7:0]  rdata;
    logic        eng_start, eng_stop, eng_tx_valid, eng_tx_ready;
    logic [7:0]  eng_tx_byte;
    logic        eng_rx_valid;
    logic [7:0]  eng_rx_byte;
    logic        busy, done;

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_mem [0:65535];
    logic [7:0] dev_mem [0:65535];
    logic [7:0] exp_tx [$];
    logic [7:0] exp_rd [$];
    bit         exp_done [$];
    logic [7:0] wq [$];

    int tx_cnt = 0, start_cnt = 0, done_cnt = 0, rd_cnt = 0, exp_start = 0;
    bit outstanding = 1'b0;
    int stall_left = 0;

    always #5 clk = ~clk;

    spi_mem_host #(.ADDR_BYTES(AB), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .eng_start(eng_start), .eng_stop(eng_stop),
        .eng_tx_valid(eng_tx_valid), .eng_tx_ready(eng_tx_ready), .eng_tx_byte(eng_tx_byte),
        .eng_rx_valid(eng_rx_valid), .eng_rx_byte(eng_rx_byte),
        .busy(busy), .done(done)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_evt(string name, logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h, required no such event (t=%0t)", name, act, $time);
    endfunction

    task automatic check_reset_outs(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_start"}, eng_start, 0);
        chk({tag, "_stop"}, eng_stop, 0);
        chk({tag, "_txv"}, eng_tx_valid, 0);
        chk({tag, "_txb"}, eng_tx_byte, 0);
        chk({tag, "_wrdy"}, wdata_ready, 0);
        chk({tag, "_rdv"}, rdata_valid, 0);
        chk({tag, "_rd"}, rdata, 0);
        chk({tag, "_cmdrdy"}, cmd_ready, 0);
    endtask

    // Scoreboard monitor: samples on the falling edge, i.e. the values that the
    // next rising edge will act on.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_byte;
        bit         e;
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall  = 1'b0;
                outstanding = 1'b0;
            end else begin
                if (eng_rx_valid) outstanding = 1'b0;
                if (eng_start) start_cnt++;
                if (prev_stall) begin
                    chk("tx_hold_valid", eng_tx_valid, 1);
                    chk("tx_hold_byte", eng_tx_byte, prev_byte);
                end
                prev_stall = eng_tx_valid && !eng_tx_ready;
                prev_byte  = eng_tx_byte;
                if (rdata_valid) chk("tx_during_rdata", eng_tx_valid, 0);
                if (eng_tx_valid && eng_tx_ready) begin
                    chk("one_outstanding", outstanding, 0);
                    outstanding = 1'b1;
                    tx_cnt++;
                    if (exp_tx.size() == 0) fail_evt("tx_unexpected", eng_tx_byte);
                    else chk("tx_byte", eng_tx_byte, exp_tx.pop_front());
                end
                if (rdata_valid) begin
                    if (exp_rd.size() == 0) fail_evt("rdata_unexpected", rdata);
                    else if (rdata_ready) begin
                        chk("rdata", rdata, exp_rd.pop_front());
                        rd_cnt++;
                    end
                end
                if (done || eng_stop) begin
                    if (exp_done.size() == 0) fail_evt("done_stop_unexpected", {done, eng_stop});
                    else begin
                        e = exp_done.pop_front();
                        chk("done_pulse", done, 1);
                        chk("stop_with_done", eng_stop, e);
                        if (e) begin
                            chk("tx_left_at_stop", exp_tx.size(), 0);
                            chk("rd_left_at_stop", exp_rd.size(), 0);
                        end
                        done_cnt++;
                    end
                end
            end
        end
    end

    // Behavioural SPI memory device on the engine side.
    initial begin
        int         delay, dslot;
        bit         pending, hs, dwrite;
        logic [7:0] resp;
        logic [15:0] daddr;
        pending = 1'b0; delay = 0; dslot = 0; dwrite = 1'b0; resp = 8'h00; daddr = 16'h0;
        eng_tx_ready = 1'b0; eng_rx_valid = 1'b0; eng_rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            hs = !rst && eng_tx_valid && eng_tx_ready;
            if (!rst && eng_start) dslot = 0;
            if (hs) begin
                resp = 8'($urandom);
                if (dslot < AB) begin
                    daddr[dslot*8 +: 8] = eng_tx_byte;
                end else if (dslot == AB) begin
                    dwrite = (eng_tx_byte == 8'h01);
                    if (!dwrite) resp = dev_mem[daddr];
                end else if (dwrite) begin
                    dev_mem[daddr + 16'(dslot - AB - 1)] = eng_tx_byte;
                end else begin
                    resp = dev_mem[daddr + 16'(dslot - AB)];
                end
                dslot++;
            end
            @(posedge clk);
            #1;
            eng_rx_valid = 1'b0;
            if (rst) pending = 1'b0;
            else if (hs) begin
                pending = 1'b1;
                delay   = $urandom_range(0, 2);
            end else if (pending) begin
                if (delay == 0) begin
                    eng_rx_valid = 1'b1;
                    eng_rx_byte  = resp;
                    pending      = 1'b0;
                end else delay--;
            end
            eng_tx_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Write data source with random gaps; holds each byte until accepted.
    initial begin
        bit take;
        wdata_valid = 1'b0;
        wdata = 8'h00;
        forever begin
            @(negedge clk);
            take = wdata_valid && wdata_ready && !rst;
            @(posedge clk);
            #1;
            if (take) begin
                void'(wq.pop_front());
                wdata_valid = 1'b0;
            end
            if (rst) wdata_valid = 1'b0;
            else if (!wdata_valid && wq.size() > 0 && $urandom_range(0, 3) != 0) begin
                wdata_valid = 1'b1;
                wdata = wq[0];
            end
        end
    end

    // Read data sink with random back-pressure and an optional forced stall.
    initial begin
        rdata_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                rdata_ready = 1'b0;
                stall_left--;
            end else rdata_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input bit wr, input logic [15:0] addr, input int len,
                         input bit wait_done);
        logic [7:0] b;
        int n, dc;
        if (len > 0) begin
            exp_tx.push_back(addr[7:0]);
            exp_tx.push_back(addr[15:8]);
            exp_tx.push_back(wr ? 8'h01 : 8'h00);
            for (int k = 0; k < len; k++) begin
                if (wr) begin
                    b = 8'($urandom);
                    wq.push_back(b);
                    exp_tx.push_back(b);
                    ref_mem[addr + 16'(k)] = b;
                end else begin
                    exp_rd.push_back(ref_mem[addr + 16'(k)]);
                    if (k < len - 1) exp_tx.push_back(8'h00);
                end
            end
            exp_start++;
        end
        exp_done.push_back(len > 0);
        dc = done_cnt;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        if (!cmd_ready) fail_evt("cmd_handshake_timeout", n);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
        cmd_len = 8'($urandom);
        @(negedge clk);
        if (len == 0) begin
            chk("len0_done_next_cycle", done, 1);
            chk("len0_not_busy", busy, 0);
        end else begin
            chk("busy_after_cmd", busy, 1);
            chk("cmd_ready_while_busy", cmd_ready, 0);
        end
        if (wait_done) begin
            n = 0;
            while (done_cnt == dc && n < 20000) begin
                @(posedge clk);
                n++;
            end
            if (done_cnt == dc) fail_evt("done_timeout", n);
            @(negedge clk);
            chk("idle_after_done", busy, 0);
            chk("start_count", start_cnt, exp_start);
        end
    endtask

    initial begin
        logic [7:0] b;
        int n, r0, t0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_len = 8'h0;
        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            ref_mem[i] = b;
            dev_mem[i] = b;
        end
        #12;
        check_reset_outs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Write 3 bytes to 0x1234.
        wq.push_back(8'hA1); wq.push_back(8'hB2); wq.push_back(8'hC3);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12); exp_tx.push_back(8'h01);
        exp_tx.push_back(8'hA1); exp_tx.push_back(8'hB2); exp_tx.push_back(8'hC3);
        ref_mem[16'h1234] = 8'hA1; ref_mem[16'h1235] = 8'hB2; ref_mem[16'h1236] = 8'hC3;
        exp_start++;
        exp_done.push_back(1'b1);
        r0 = done_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h1234; cmd_len = 8'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (done_cnt == r0 && n < 2000) begin @(posedge clk); n++; end
        if (done_cnt == r0) fail_evt("write_done_timeout", n);
        chk("write_start_count", start_cnt, exp_start);

        // Read back what was written, and a single-byte read of a preset location.
        issue(1'b0, 16'h1234, 3, 1'b1);
        ref_mem[16'h0010] = 8'h5A;
        dev_mem[16'h0010] = 8'h5A;
        issue(1'b0, 16'h0010, 1, 1'b1);

        // Read with the consumer stalled for 5 cycles after the first byte.
        r0 = rd_cnt;
        fork
            issue(1'b0, 16'h0300, 3, 1'b1);
            begin
                n = 0;
                while (rd_cnt == r0 && n < 2000) begin @(posedge clk); n++; end
                stall_left = 5;
            end
        join

        // Zero-length command.
        issue(1'b1, 16'h4444, 0, 1'b1);
        issue(1'b0, 16'h4444, 0, 1'b1);

        // Random mix over a small address window so reads hit earlier writes.
        for (int t = 0; t < 24; t++) begin
            issue(1'($urandom), 16'h0200 + 16'($urandom_range(0, 15)),
                  $urandom_range(0, 6), 1'b1);
        end

        // Longest transaction, wrapping the 16-bit address.
        issue(1'b1, 16'hFF80, 255, 1'b1);
        issue(1'b0, 16'hFF80, 255, 1'b1);

        // Reset while waiting for the DIR slot's rx byte of a read.
        t0 = tx_cnt;
        issue(1'b0, 16'h1234, 4, 1'b0);
        n = 0;
        while (!(outstanding && tx_cnt >= t0 + 3) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (!(outstanding && tx_cnt >= t0 + 3)) fail_evt("reach_wait_rx_timeout", n);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outs("midreset");
        exp_tx.delete(); exp_rd.delete(); exp_done.delete(); wq.delete();
        repeat (3) @(posedge clk);
        #2;
        chk("cmd_ready_in_reset", cmd_ready, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        issue(1'b0, 16'h1234, 3, 1'b1);
        issue(1'b1, 16'h0500, 2, 1'b1);
        issue(1'b0, 16'h0500, 2, 1'b1);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/spi_mem_host.md
SPI_MEM_HOST -- requirements
Module: spi_mem_host

Interface
REQ-001 Parameter ADDR_BYTES, default 1, SHALL set the number of address bytes sent per transaction.
REQ-002 Parameter LEN_WIDTH, default 8, SHALL set the width of the transaction byte count.
REQ-003 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake; cmd_write in 1, cmd_addr in ADDR_BYTES*8, cmd_len in LEN_WIDTH, sampled on the handshake.
REQ-006 wdata_valid/wdata_ready/wdata  in/out/in  1/1/8  write byte stream.
REQ-007 rdata_valid/rdata_ready/rdata  out/in/out  1/1/8  read byte stream.
REQ-008 eng_start, eng_stop  out  1  single-cycle pulses to the SPI byte engine (chip-select assert / release).
REQ-009 eng_tx_valid/eng_tx_ready/eng_tx_byte  out/in/out  1/1/8  byte to shift out.
REQ-010 eng_rx_valid/eng_rx_byte  in/in  1/8  byte shifted in; exactly one per accepted tx byte, arriving at least 1 cycle later.
REQ-011 busy out 1 high outside IDLE; done out 1 single-cycle pulse at transaction end.

Function
REQ-012 States SHALL be IDLE, START, ADDR, DIR, DATA, WAIT_RX, STOP.
REQ-013 cmd_ready SHALL be high only in IDLE; a handshake latches the command and moves to START, or, if cmd_len==0, stays in IDLE and pulses done next cycle with no engine activity.
REQ-014 START SHALL pulse eng_start for one cycle, then enter ADDR.
REQ-015 ADDR SHALL send cmd_addr bytes least-significant first, ADDR_BYTES bytes total.
REQ-016 DIR SHALL send 0x01 for write, 0x00 for read.
REQ-017 Write: DATA SHALL send cmd_len bytes from the wdata stream, to addr, addr+1, ...; eng_tx_valid = wdata_valid and wdata_ready = eng_tx_ready in DATA, combinationally.
REQ-018 Read: DATA SHALL send cmd_len-1 bytes of 0x00; the rx byte of the DIR slot SHALL be read byte 0 (mem[addr]); the rx byte of data slot k SHALL be read byte k+1.
REQ-019 Only one byte SHALL be outstanding: after each tx handshake the FSM enters WAIT_RX and issues no tx until eng_rx_valid.
REQ-020 Rx bytes of ADDR slots, and of all slots in a write, SHALL be discarded.
REQ-021 A read rx byte SHALL be registered onto rdata with rdata_valid the cycle after eng_rx_valid, held until rdata_ready; no further tx SHALL issue while rdata_valid is high.
REQ-022 After the last slot's rx (and, for reads, the last rdata handshake), STOP SHALL pulse eng_stop and done together for one cycle, then return to IDLE.
REQ-023 Slot counter SHALL count ADDR_BYTES+1+(write ? cmd_len : cmd_len-1) slots without overflow for cmd_len up to 2^LEN_WIDTH-1.
REQ-024 eng_tx_byte SHALL be stable while eng_tx_valid is high and eng_tx_ready is low.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, busy=0, done=0, eng_start=0, eng_stop=0, eng_tx_valid=0, eng_tx_byte=0, wdata_ready=0, rdata_valid=0, rdata=0, and cmd_ready=0 while rst is high.
REQ-026 Reset mid-transaction SHALL abort without issuing eng_stop; the partial rx byte SHALL be dropped.

Structure
REQ-027 A shared package SHALL hold the state encoding and the DIR_WRITE=0x01 / DIR_READ=0x00 constants, shared with the SPI-slave-to-APB bridge.
REQ-028 The block SHALL be a single module with no sub-modules.

Verification
REQ-029 ADDR_BYTES=2, write len 3 to 0x1234, data A1 B2 C3 -> eng_start; tx 34 12 01 A1 B2 C3; eng_stop and done together; no rdata_valid.
REQ-030 ADDR_BYTES=1, read len 1 at 0x10, rx bytes xx 5A -> tx 10 00; rdata 5A once; done.
REQ-031 Read len 3 with rdata_ready low for 5 cycles after the first rdata -> no tx during the stall; rdata order preserved; 4 tx bytes total.
REQ-032 cmd_len 0 -> done one cycle after the handshake; no eng_start, eng_stop or eng_tx_valid.
REQ-033 Write with wdata_valid gapped and eng_tx_ready toggling -> tx bytes unchanged while stalled; none lost or duplicated.
REQ-034 rst asserted in WAIT_RX of a read -> outputs at reset values immediately; no eng_stop; next command runs normally.
